// File: rtl/spi_cmd_decoder_pkg.sv
// Opcodes and FSM encodings shared by the SPI command decoder and its register bank.
// No logic here; constants only.
// Consumers decide how to use them.
package spi_cmd_decoder_pkg;

  localparam logic [7:0] OP_CLR      = 8'hCC;
  localparam logic [7:0] OP_LED_ON   = 8'hCD;
  localparam logic [7:0] OP_LED_OFF  = 8'hCE;
  localparam logic [3:0] OP_WR_HI    = 4'h1;
  localparam logic [3:0] OP_RD_HI    = 4'h2;
  localparam logic [3:0] RD_COUNT_LO = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// NREGS x 32-bit register bank with one write port and a flat read bus.
// Latency: a write is visible on regs_flat the cycle after wr_en is sampled.
// No backpressure: every write strobe is accepted.
module spi_reg_bank #(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [31:0]            wr_data,
  output logic [32*NREGS-1:0]    regs_flat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_flat <= '0;
    end else if (wr_en) begin
      regs_flat[{wr_addr, 5'd0} +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses SSEL-framed SPI byte streams into commands, register writes and read-back words.
// Latency: command effects 1 cycle after the command byte; wr_en 1 cycle after the 4th payload byte.
// No backpressure: bytes arrive as strobes and are consumed or dropped in the same cycle.
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int ERRW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       frame_end,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  input  logic [31:0]                count,
  output logic                       cnt_clear,
  output logic                       led,
  output logic                       wr_en,
  output logic [$clog2(NREGS)-1:0]   wr_addr,
  output logic [32*NREGS-1:0]        regs_flat,
  output logic [31:0]                tx_word,
  output logic [ERRW-1:0]            err_count
);

  localparam int AW = $clog2(NREGS);
  localparam logic [4:0] NREGS5 = 5'(NREGS);

  state_t          state;
  logic [AW-1:0]   addr;
  logic [1:0]      idx;
  logic [23:0]     acc;

  logic [3:0]      op_hi;
  logic [3:0]      op_lo;
  logic            lo_ok;
  logic            is_wr;
  logic            is_rd;
  logic            is_rd_cnt;
  logic            is_misc;
  logic            cmd_ok;
  logic            take;
  logic            commit;
  logic            err_inc;
  logic [31:0]     rd_word;
  logic [31:0]     wr_data;

  // frame_start overrides a same-cycle byte, so every byte-consuming path goes through take.
  always_comb begin
    op_hi     = byte_data[7:4];
    op_lo     = byte_data[3:0];
    lo_ok     = {1'b0, op_lo} < NREGS5;
    is_rd_cnt = byte_data == {OP_RD_HI, RD_COUNT_LO};
    is_wr     = (op_hi == OP_WR_HI) && lo_ok;
    is_rd     = (op_hi == OP_RD_HI) && lo_ok && !is_rd_cnt;
    is_misc   = (byte_data == OP_CLR) || (byte_data == OP_LED_ON) || (byte_data == OP_LED_OFF);
    cmd_ok    = is_wr || is_rd || is_rd_cnt || is_misc;
    take      = byte_valid && !frame_start;
    commit    = take && (state == ST_PAYLOAD) && (idx == 2'd3);
    err_inc   = (take && (state == ST_CMD) && !cmd_ok) ||
                (!frame_start && frame_end && (state == ST_PAYLOAD) && !commit);
    rd_word   = regs_flat[{op_lo[AW-1:0], 5'd0} +: 32];
    wr_data   = {acc, byte_data};
  end

  spi_reg_bank #(
    .NREGS (NREGS)
  ) u_reg_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (commit),
    .wr_addr   (addr),
    .wr_data   (wr_data),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      idx       <= '0;
      acc       <= '0;
      cnt_clear <= 1'b0;
      led       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      tx_word   <= '0;
      err_count <= '0;
    end else begin
      cnt_clear <= 1'b0;
      wr_en     <= 1'b0;

      if (err_inc && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end

      if (frame_start) begin
        state <= ST_CMD;
        idx   <= '0;
      end else begin
        case (state)
          ST_CMD: begin
            if (take) begin
              if (is_wr) begin
                addr  <= op_lo[AW-1:0];
                idx   <= '0;
                state <= ST_PAYLOAD;
              end else begin
                state <= ST_DISCARD;
                if (byte_data == OP_CLR)     cnt_clear <= 1'b1;
                if (byte_data == OP_LED_ON)  led       <= 1'b1;
                if (byte_data == OP_LED_OFF) led       <= 1'b0;
                if (is_rd_cnt)               tx_word   <= count;
                else if (is_rd)              tx_word   <= rd_word;
              end
            end
          end
          ST_PAYLOAD: begin
            if (take) begin
              acc <= {acc[15:0], byte_data};
              idx <= idx + 2'd1;
              if (commit) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                state   <= ST_DISCARD;
              end
            end
          end
          default: ;
        endcase
        // Same-cycle byte has already been handled above; frame close wins the state.
        if (frame_end) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: stimulus pushes expected events, a monitor pops them.
module tb_spi_cmd_decoder;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic [31:0]   count = 32'h0;
  logic          cnt_clear;
  logic          led;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [127:0]  regs_flat;
  logic [31:0]   tx_word;
  logic [7:0]    err_count;

  spi_cmd_decoder #(
    .NREGS (4),
    .ERRW  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .count       (count),
    .cnt_clear   (cnt_clear),
    .led         (led),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .regs_flat   (regs_flat),
    .tx_word     (tx_word),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_NONE, EV_WR, EV_CLR, EV_LED, EV_TX, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic drive(input logic fs, input logic fe, input logic bv, input logic [7:0] b,
                       input ev_kind_t k, input int a, input logic [31:0] d);
    ev_t e;
    @(posedge clk); #1;
    frame_start = fs;
    frame_end   = fe;
    byte_valid  = bv;
    byte_data   = b;
    if (k != EV_NONE) begin
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    byte_valid  = 1'b0;
  endtask

  task automatic fstart();
    drive(1'b1, 1'b0, 1'b0, 8'h00, EV_NONE, 0, 32'h0);
  endtask

  task automatic fend();
    drive(1'b0, 1'b1, 1'b0, 8'h00, EV_NONE, 0, 32'h0);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, 1'b0, 1'b1, b, EV_NONE, 0, 32'h0);
  endtask

  task automatic cmd_frame(input logic [7:0] b, input ev_kind_t k, input logic [31:0] d);
    fstart();
    drive(1'b0, 1'b0, 1'b1, b, k, 0, d);
    fend();
  endtask

  task automatic wr_frame(input int a, input logic [31:0] d, input logic end_on_last);
    fstart();
    send(8'(8'h10 + a));
    send(d[31:24]);
    send(d[23:16]);
    send(d[15:8]);
    drive(1'b0, end_on_last, 1'b1, d[7:0], EV_WR, a, d);
    if (!end_on_last) fend();
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic observe(input ev_kind_t k, input int a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h at cycle %0d, required no event",
               k, a, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr != a || e.data !== d || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=%0d data=%h cycle=%0d, required kind=%0d addr=%0d data=%h cycle=%0d",
                 k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  logic        prev_led;
  logic [31:0] prev_tx;
  logic [7:0]  prev_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)                 observe(EV_WR, int'(wr_addr), regs_flat[{wr_addr, 5'd0} +: 32]);
      if (cnt_clear)             observe(EV_CLR, 0, 32'h0);
      if (led !== prev_led)      observe(EV_LED, 0, {31'd0, led});
      if (tx_word !== prev_tx)   observe(EV_TX, 0, tx_word);
      if (err_count !== prev_err) observe(EV_ERR, 0, {24'd0, err_count});
    end
    prev_led = led;
    prev_tx  = tx_word;
    prev_err = err_count;
  end

  int err_m;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", {127'd0, led}, 128'd0);
    chk("reset_tx_word", {96'd0, tx_word}, 128'd0);
    chk("reset_err_count", {120'd0, err_count}, 128'd0);
    chk("reset_regs", regs_flat, 128'd0);
    chk("reset_strobes", {125'd0, wr_en, cnt_clear, 1'b0}, 128'd0);
    rst = 1'b0;

    // Write then read back register 2.
    wr_frame(2, 32'hDEADBEEF, 1'b0);
    cmd_frame(8'h22, EV_TX, 32'hDEADBEEF);

    // LED on/off and a single counter-clear pulse.
    cmd_frame(8'hCD, EV_LED, 32'h1);
    cmd_frame(8'hCE, EV_LED, 32'h0);
    cmd_frame(8'hCC, EV_CLR, 32'h0);

    // Aborted write to reg1 must leave its earlier value intact.
    wr_frame(1, 32'h01234567, 1'b0);
    fstart();
    send(8'h11);
    send(8'h01);
    send(8'h02);
    drive(1'b0, 1'b1, 1'b0, 8'h00, EV_ERR, 0, 32'h1);
    cmd_frame(8'h21, EV_TX, 32'h01234567);

    // Unknown opcode and out-of-range write address.
    cmd_frame(8'h55, EV_ERR, 32'h2);
    cmd_frame(8'h17, EV_ERR, 32'h3);

    // Byte coincident with frame_start is dropped; next byte is the command.
    drive(1'b1, 1'b0, 1'b1, 8'h55, EV_NONE, 0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 8'hCD, EV_LED, 0, 32'h1);
    fend();

    // Fourth payload byte together with frame_end still commits.
    wr_frame(3, 32'hCAFEBABE, 1'b1);
    cmd_frame(8'h23, EV_TX, 32'hCAFEBABE);

    // Count snapshot taken at decode, not tracked afterwards.
    count = 32'h12345678;
    cmd_frame(8'h2F, EV_TX, 32'h12345678);
    count = 32'h99999999;
    repeat (3) @(posedge clk);

    // Empty frame is harmless.
    fstart();
    fend();

    // Reset in the middle of a write payload.
    fstart();
    send(8'h10);
    send(8'hAA);
    send(8'hBB);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_led", {127'd0, led}, 128'd0);
    chk("midreset_tx_word", {96'd0, tx_word}, 128'd0);
    chk("midreset_err_count", {120'd0, err_count}, 128'd0);
    chk("midreset_regs", regs_flat, 128'd0);
    chk("midreset_wr", {126'd0, wr_addr}, 128'd0);
    rst = 1'b0;
    wr_frame(0, 32'h01020304, 1'b0);
    chk("post_reset_reg0", regs_flat, {96'd0, 32'h01020304});

    // Error counter saturates at 255.
    err_m = 0;
    for (int i = 0; i < 300; i++) begin
      fstart();
      drive(1'b0, 1'b0, 1'b1, 8'h55, (err_m < 255) ? EV_ERR : EV_NONE, 0, 32'(err_m + 1));
      fend();
      if (err_m < 255) err_m++;
    end
    chk("err_saturated", {120'd0, err_count}, {120'd0, 8'hFF});

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
